ex_mem_skid: RTL and testbench
==============================

EX_MEM_SKID -- requirements
Module: ex_mem_skid

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the result data width (RegBus).
REQ-002 Parameter ADDR_W, default 5, SHALL set the destination register address width (RegAddrBus).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset (RstEnable = 1).
REQ-005 flush_i  input  1  SHALL be the synchronous pipeline flush request from the control unit.
REQ-006 ex_valid_i  input  1  SHALL mark an EX result present this cycle.
REQ-007 ex_ready_o  output  1  SHALL indicate the block accepts an EX result this cycle.
REQ-008 ex_wd_i  input  ADDR_W  SHALL be the EX destination register address.
REQ-009 ex_wreg_i  input  1  SHALL be the EX register-write enable.
REQ-010 ex_wdata_i  input  DATA_W  SHALL be the EX result (e.g. logicout).
REQ-011 mem_valid_o  output  1  SHALL mark a result presented to MEM.
REQ-012 mem_ready_i  input  1  SHALL indicate MEM consumes the presented result.
REQ-013 mem_wd_o / mem_wreg_o / mem_wdata_o  output  ADDR_W / 1 / DATA_W  SHALL be the presented result fields.
REQ-014 occ_o  output  2  SHALL report entries held (0..2).

Function
REQ-015 Accept SHALL occur on a rising edge with ex_valid_i=1 and ex_ready_o=1; take SHALL occur with mem_valid_o=1 and mem_ready_i=1.
REQ-016 Storage SHALL be a main register (drives mem_*_o) plus a skid register; states EMPTY (occ 0), BUSY (occ 1), FULL (occ 2).
REQ-017 EMPTY: accept -> BUSY, entry loaded into main; otherwise stay.
REQ-018 BUSY: accept and take -> BUSY, new entry into main; accept only -> FULL, new entry into skid; take only -> EMPTY; neither -> stay.
REQ-019 FULL: take -> BUSY, skid moves to main; accept impossible (ex_ready_o=0).
REQ-020 ex_ready_o SHALL be registered: 1 in EMPTY and BUSY, 0 in FULL; no combinational path from mem_ready_i.
REQ-021 Entries SHALL leave in acceptance order; no entry duplicated or dropped except by flush.
REQ-022 Latency SHALL be one cycle: an entry accepted at edge N is presented after edge N when main is empty or taken at N.
REQ-023 While mem_valid_o=1 and mem_ready_i=0, mem_*_o SHALL hold stable.
REQ-024 When mem_valid_o=0, mem_wd_o=0, mem_wreg_o=0 (WriteDisable), mem_wdata_o=0 (ZeroWord).
REQ-025 Entries with ex_wreg_i=0 SHALL pass through as ordinary entries.
REQ-026 flush_i=1 at an edge SHALL force EMPTY, zero all data outputs, and discard any simultaneous accept or take.
REQ-027 mem_valid_o SHALL equal (occ_o != 0).

Reset
REQ-028 rst=1 SHALL immediately, asynchronously, force EMPTY: occ_o=0, mem_valid_o=0, mem_wd_o=0, mem_wreg_o=0, mem_wdata_o=0, ex_ready_o=1.
REQ-029 Reset asserted mid-operation SHALL discard all held entries; first accept allowed on the first edge after rst deasserts.

Configuration
REQ-030 Macro EX_MEM_SKID_EN defined: behaviour per REQ-016..REQ-020, full throughput with registered ready.
REQ-031 EX_MEM_SKID_EN undefined: skid register omitted; single stage; ex_ready_o = !mem_valid_o || mem_ready_i (combinational); occ_o never exceeds 1; FULL unreachable; all other requirements unchanged.

Verification
REQ-032 Reset then ex_valid_i=1, wd=5, wreg=1, wdata=0x0000_F0F0, mem_ready_i=1 -> next cycle mem_valid_o=1, mem_wd_o=5, mem_wdata_o=0x0000_F0F0, occ_o=1.
REQ-033 Back-to-back 0x1,0x2,0x3 with mem_ready_i=0 -> occ_o 1 then 2, ex_ready_o=0 after 2nd accept, mem_wdata_o holds 0x1; raise mem_ready_i -> outputs 0x1,0x2,0x3 in order, no loss.
REQ-034 Continuous stream 0x10..0x1F with mem_ready_i=1 -> one result per cycle, ex_ready_o constantly 1, occ_o=1.
REQ-035 occ_o=2 holding 0xA,0xB, flush_i=1 with ex_valid_i=1 wdata=0xC -> next cycle occ_o=0, mem_valid_o=0, all outputs 0, 0xC never appears.
REQ-036 rst pulsed asynchronously between edges with occ_o=1 -> outputs zero before next edge; ex_ready_o=1.
REQ-037 Macro undefined: mem_ready_i=0 with main full -> ex_ready_o=0 same cycle; mem_ready_i=1 -> ex_ready_o=1 same cycle, occ_o never 2.

Source files
------------

// File: rtl/ex_mem_skid.sv
// ex_mem_skid: EX->MEM pipeline register with valid/ready handshake.
//
// Build option: define EX_MEM_SKID_EN to add a second (skid) register.
// This gives full throughput with a registered ex_ready_o. Without it the
// block is a single stage whose ex_ready_o depends combinationally on
// mem_ready_i.
//
// Ports:
//   clk, rst      - clock; asynchronous active-high reset
//   flush_i       - synchronous flush; empties the block and zeroes the outputs
//   ex_valid_i    - EX result present
//   ex_ready_o    - block accepts an EX result this cycle
//   ex_wd_i, ex_wreg_i, ex_wdata_i - EX destination, write enable, result
//   mem_valid_o   - result presented to MEM (equals occ_o != 0)
//   mem_ready_i   - MEM consumes the presented result
//   mem_wd_o, mem_wreg_o, mem_wdata_o - presented fields (zero when not valid)
//   occ_o         - entries held (0..2)
module ex_mem_skid #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [ADDR_W-1:0] ex_wd_i,
  input  logic              ex_wreg_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] mem_wd_o,
  output logic              mem_wreg_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [1:0]        occ_o
);

  // Main register: always the entry presented to MEM.
  logic              r_valid;
  logic [ADDR_W-1:0] r_wd;
  logic              r_wreg;
  logic [DATA_W-1:0] r_wdata;

  logic w_accept;
  logic w_take;

  assign mem_valid_o = r_valid;
  assign mem_wd_o    = r_wd;
  assign mem_wreg_o  = r_wreg;
  assign mem_wdata_o = r_wdata;
  assign w_take      = r_valid & mem_ready_i;

`ifdef EX_MEM_SKID_EN

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_ex_ready;
  logic [1:0]        r_occ;
  logic [ADDR_W-1:0] r_skid_wd;
  logic              r_skid_wreg;
  logic [DATA_W-1:0] r_skid_wdata;

  assign ex_ready_o = r_ex_ready;
  assign occ_o      = r_occ;
  assign w_accept   = ex_valid_i & r_ex_ready;

  // Occupancy FSM; the registered ready drops only in FULL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_EMPTY;
      r_ex_ready   <= 1'b1;
      r_occ        <= 2'd0;
      r_valid      <= 1'b0;
      r_wd         <= '0;
      r_wreg       <= 1'b0;
      r_wdata      <= '0;
      r_skid_wd    <= '0;
      r_skid_wreg  <= 1'b0;
      r_skid_wdata <= '0;
    end else if (flush_i) begin
      r_state      <= S_EMPTY;
      r_ex_ready   <= 1'b1;
      r_occ        <= 2'd0;
      r_valid      <= 1'b0;
      r_wd         <= '0;
      r_wreg       <= 1'b0;
      r_wdata      <= '0;
      r_skid_wd    <= '0;
      r_skid_wreg  <= 1'b0;
      r_skid_wdata <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_state <= S_BUSY;
            r_occ   <= 2'd1;
            r_valid <= 1'b1;
            r_wd    <= ex_wd_i;
            r_wreg  <= ex_wreg_i;
            r_wdata <= ex_wdata_i;
          end
        end
        S_BUSY: begin
          if (w_accept && w_take) begin
            r_wd    <= ex_wd_i;
            r_wreg  <= ex_wreg_i;
            r_wdata <= ex_wdata_i;
          end else if (w_accept) begin
            // Main is stalled, so the new entry parks in the skid.
            r_state      <= S_FULL;
            r_occ        <= 2'd2;
            r_ex_ready   <= 1'b0;
            r_skid_wd    <= ex_wd_i;
            r_skid_wreg  <= ex_wreg_i;
            r_skid_wdata <= ex_wdata_i;
          end else if (w_take) begin
            r_state <= S_EMPTY;
            r_occ   <= 2'd0;
            r_valid <= 1'b0;
            r_wd    <= '0;
            r_wreg  <= 1'b0;
            r_wdata <= '0;
          end
        end
        S_FULL: begin
          if (w_take) begin
            r_state      <= S_BUSY;
            r_occ        <= 2'd1;
            r_ex_ready   <= 1'b1;
            r_wd         <= r_skid_wd;
            r_wreg       <= r_skid_wreg;
            r_wdata      <= r_skid_wdata;
            r_skid_wd    <= '0;
            r_skid_wreg  <= 1'b0;
            r_skid_wdata <= '0;
          end
        end
        default: begin
          r_state    <= S_EMPTY;
          r_ex_ready <= 1'b1;
          r_occ      <= 2'd0;
          r_valid    <= 1'b0;
          r_wd       <= '0;
          r_wreg     <= 1'b0;
          r_wdata    <= '0;
        end
      endcase
    end
  end

`else

  // Single stage: room exists when empty or when the held entry leaves now.
  assign ex_ready_o = ~r_valid | mem_ready_i;
  assign occ_o      = {1'b0, r_valid};
  assign w_accept   = ex_valid_i & ex_ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_wd    <= '0;
      r_wreg  <= 1'b0;
      r_wdata <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
      r_wd    <= '0;
      r_wreg  <= 1'b0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_wd    <= ex_wd_i;
      r_wreg  <= ex_wreg_i;
      r_wdata <= ex_wdata_i;
    end else if (w_take) begin
      r_valid <= 1'b0;
      r_wd    <= '0;
      r_wreg  <= 1'b0;
      r_wdata <= '0;
    end
  end

`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
module tb_ex_mem_skid;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
  } ent_t;

`ifdef EX_MEM_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic        ex_ready_o;
  logic [4:0]  ex_wd_i = '0;
  logic        ex_wreg_i = 1'b0;
  logic [31:0] ex_wdata_i = '0;
  logic        mem_valid_o;
  logic        mem_ready_i = 1'b0;
  logic [4:0]  mem_wd_o;
  logic        mem_wreg_o;
  logic [31:0] mem_wdata_o;
  logic [1:0]  occ_o;

  int vectors = 0;
  int miscompares = 0;
  ent_t q[$];

  ex_mem_skid #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .ex_wd_i(ex_wd_i), .ex_wreg_i(ex_wreg_i), .ex_wdata_i(ex_wdata_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
    .mem_wd_o(mem_wd_o), .mem_wreg_o(mem_wreg_o), .mem_wdata_o(mem_wdata_o),
    .occ_o(occ_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: FIFO of capacity CAP; head is presented, empty presents zeros.
  function automatic logic model_ready(input logic mr);
`ifdef EX_MEM_SKID_EN
    return q.size() < CAP;
`else
    return (q.size() == 0) || mr;
`endif
  endfunction

  task automatic check_model();
    ent_t h;
    h = (q.size() > 0) ? q[0] : '0;
    chk("valid", 32'(mem_valid_o), 32'(q.size() > 0));
    chk("occ",   32'(occ_o),       32'(q.size()));
    chk("wd",    32'(mem_wd_o),    32'(h.wd));
    chk("wreg",  32'(mem_wreg_o),  32'(h.wreg));
    chk("wdata", mem_wdata_o,      h.wdata);
    chk("ready", 32'(ex_ready_o),  32'(model_ready(mem_ready_i)));
  endtask

  // One clock: drive at negedge, check, then advance the model at posedge.
  task automatic cycle(input logic v, input ent_t e, input logic mr, input logic fl);
    logic acc, tk;
    @(negedge clk);
    ex_valid_i = v; ex_wd_i = e.wd; ex_wreg_i = e.wreg; ex_wdata_i = e.wdata;
    mem_ready_i = mr; flush_i = fl;
    #1;
    check_model();
    acc = v && model_ready(mr);
    tk  = (q.size() > 0) && mr;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (tk) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    #1;
  endtask

  function automatic ent_t mk(input logic [4:0] wd, input logic wreg, input logic [31:0] d);
    ent_t e;
    e.wd = wd; e.wreg = wreg; e.wdata = d;
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ex_valid_i = 1'b0; flush_i = 1'b0; mem_ready_i = 1'b0;
    q.delete();
    @(negedge clk);
    #1;
    check_model();
    rst = 1'b0;
  endtask

  initial begin
    ent_t e;
    do_reset();

    // Single entry, one-cycle latency.
    cycle(1'b1, mk(5'd5, 1'b1, 32'h0000_F0F0), 1'b1, 1'b0);
    chk("lit_valid", 32'(mem_valid_o), 32'd1);
    chk("lit_wd", 32'(mem_wd_o), 32'd5);
    chk("lit_wdata", mem_wdata_o, 32'h0000_F0F0);
    chk("lit_occ", 32'(occ_o), 32'd1);
    cycle(1'b0, mk(5'd0, 1'b0, 32'h0), 1'b1, 1'b0);

    // Backpressure then drain, in order.
    cycle(1'b1, mk(5'd1, 1'b1, 32'h1), 1'b0, 1'b0);
    chk("bp_occ1", 32'(occ_o), 32'd1);
`ifdef EX_MEM_SKID_EN
    cycle(1'b1, mk(5'd2, 1'b0, 32'h2), 1'b0, 1'b0);
    chk("bp_occ2", 32'(occ_o), 32'd2);
    chk("bp_rdy0", 32'(ex_ready_o), 32'd0);
    chk("bp_hold", mem_wdata_o, 32'h1);
    cycle(1'b1, mk(5'd3, 1'b1, 32'h3), 1'b0, 1'b0);
    chk("bp_hold2", mem_wdata_o, 32'h1);
    cycle(1'b1, mk(5'd3, 1'b1, 32'h3), 1'b1, 1'b0);
    chk("bp_out2", mem_wdata_o, 32'h2);
    cycle(1'b1, mk(5'd3, 1'b1, 32'h3), 1'b1, 1'b0);
    chk("bp_out3", mem_wdata_o, 32'h3);
`else
    chk("comb_rdy0", 32'(ex_ready_o), 32'd0);
    mem_ready_i = 1'b1;
    #1;
    chk("comb_rdy1", 32'(ex_ready_o), 32'd1);
    cycle(1'b1, mk(5'd2, 1'b0, 32'h2), 1'b0, 1'b0);
    chk("bp_hold", mem_wdata_o, 32'h1);
    cycle(1'b1, mk(5'd2, 1'b0, 32'h2), 1'b1, 1'b0);
    chk("bp_out2", mem_wdata_o, 32'h2);
    chk("bp_occ", 32'(occ_o), 32'd1);
`endif
    cycle(1'b0, mk(5'd0, 1'b0, 32'h0), 1'b1, 1'b0);
    chk("drain_valid", 32'(mem_valid_o), 32'd0);

    // Streaming at full rate.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, mk(5'(i), 1'b1, 32'h10 + 32'(i)), 1'b1, 1'b0);
      chk("strm_data", mem_wdata_o, 32'h10 + 32'(i));
      chk("strm_rdy", 32'(ex_ready_o), 32'd1);
      chk("strm_occ", 32'(occ_o), 32'd1);
    end
    cycle(1'b0, mk(5'd0, 1'b0, 32'h0), 1'b1, 1'b0);

    // Flush with a simultaneous accept.
    cycle(1'b1, mk(5'd10, 1'b1, 32'hA), 1'b0, 1'b0);
    cycle(1'b1, mk(5'd11, 1'b1, 32'hB), 1'b0, 1'b0);
    chk("fl_pre_occ", 32'(occ_o), 32'(CAP));
    cycle(1'b1, mk(5'd12, 1'b1, 32'hC), 1'b1, 1'b1);
    chk("fl_occ", 32'(occ_o), 32'd0);
    chk("fl_valid", 32'(mem_valid_o), 32'd0);
    chk("fl_wdata", mem_wdata_o, 32'h0);
    chk("fl_wd", 32'(mem_wd_o), 32'd0);
    cycle(1'b0, mk(5'd0, 1'b0, 32'h0), 1'b1, 1'b0);
    chk("fl_noC", 32'(mem_wdata_o == 32'hC), 32'd0);

    // Asynchronous reset between edges.
    cycle(1'b1, mk(5'd7, 1'b1, 32'h77), 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 32'(mem_valid_o), 32'd0);
    chk("ar_occ", 32'(occ_o), 32'd0);
    chk("ar_wdata", mem_wdata_o, 32'h0);
    chk("ar_wreg", 32'(mem_wreg_o), 32'd0);
    chk("ar_rdy", 32'(ex_ready_o), 32'd1);
    q.delete();
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      e = mk(5'($urandom), 1'($urandom), $urandom);
      cycle(1'($urandom_range(0, 3) != 0), e,
            1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 39) == 0));
    end
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
